nios_debug_action_sequencer: RTL and testbench
==============================================

NIOS_DEBUG_ACTION_SEQUENCER -- requirements
Module: nios_debug_action_sequencer

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, command queue depth (power of 2); TIMEOUT, default 255, max mem_ack wait cycles.
REQ-002 Port: clk  in  1  sole clock; all logic rising-edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: take_action_ocimem_a, take_action_ocimem_b, take_action_break_a, take_action_break_b, take_action_break_c, take_action_tracectrl  in  1 each  single-cycle command strobes, clk domain.
REQ-005 Port: jdo  in  38  command payload, valid in the strobe cycle.
REQ-006 Ports: mem_req out 1, mem_write out 1, mem_addr out 9, mem_wdata out 32  OCI memory request.
REQ-007 Ports: mem_ack in 1, mem_rdata in 32  OCI memory completion; rdata valid with ack.
REQ-008 Ports: brk_wr out 1, brk_sel out 2, brk_data out 32  break/trace register write strobe.
REQ-009 Ports: MonDReg out 32, monitor_ready out 1, monitor_error out 1  host-visible result.
REQ-010 Ports: cmd_overflow out 1, cmd_collision out 1  sticky error flags.

Function
REQ-011 Opcodes SHALL be: 0 OCIMEM_A, 1 OCIMEM_B, 2 BREAK_A, 3 BREAK_B, 4 BREAK_C, 5 TRACECTRL.
REQ-012 Strobe SHALL push {opcode, jdo} (41 bits) into the FIFO in the same cycle.
REQ-013 Multiple strobes in one cycle: push only the highest priority (opcode 0 highest, 5 lowest); drop rest; set cmd_collision.
REQ-014 Push while FIFO full: command dropped, FIFO unchanged, cmd_overflow set; push with simultaneous pop while full SHALL succeed.
REQ-015 FSM states: IDLE, EXEC, WAIT, COMPLETE.
REQ-016 IDLE: FIFO non-empty -> pop head into command register, clear monitor_ready, go EXEC; else stay.
REQ-017 EXEC OCIMEM_A: addr reg <= jdo[8:0]; jdo[17]=1 -> mem_req=1, mem_write=0, mem_addr=jdo[8:0], go WAIT; jdo[17]=0 -> go COMPLETE.
REQ-018 EXEC OCIMEM_B: mem_req=1, mem_write=1, mem_addr=addr reg, mem_wdata=jdo[34:3], go WAIT.
REQ-019 EXEC BREAK_A/B/C/TRACECTRL: one-cycle brk_wr=1, brk_sel=opcode-2, brk_data=jdo[31:0], go COMPLETE.
REQ-020 WAIT: hold mem_req/mem_write/mem_addr/mem_wdata stable until mem_ack; on ack go COMPLETE; ack in cycle mem_req first asserted is legal.
REQ-021 Read ack: MonDReg <= mem_rdata; write ack: addr reg <= addr reg + 1, wrapping 511 -> 0.
REQ-022 Timeout: counter cleared entering WAIT; TIMEOUT cycles without ack -> drop mem_req, set monitor_error, MonDReg unchanged, go COMPLETE.
REQ-023 COMPLETE: monitor_ready <= 1 for one state cycle then held until next pop; go IDLE.
REQ-024 monitor_error SHALL clear on next OCIMEM_A pop; cmd_overflow/cmd_collision clear only on reset.
REQ-025 Latency: strobe in cycle N with FSM IDLE and FIFO empty -> mem_req or brk_wr in cycle N+2.
REQ-026 mem_ack outside WAIT SHALL be ignored.

Reset
REQ-027 On reset: FSM IDLE, FIFO empty, addr reg 0, MonDReg 0, monitor_ready 1, monitor_error 0, mem_req 0, brk_wr 0, flags 0, all other outputs 0.
REQ-028 Reset mid-WAIT SHALL drop mem_req next cycle; late mem_ack after reset ignored.

Structure
REQ-029 Package nios_debug_pkg SHALL hold opcode enum, FSM state enum, 41-bit command struct, brk_sel constants.
REQ-030 One sub-module debug_cmd_fifo (synchronous FIFO, full/empty, parameterised depth/width).

Verification
REQ-031 take_action_ocimem_a, jdo[17]=1, jdo[8:0]=0x010; ack after 3 cycles rdata=0xCAFEF00D -> mem_req at N+2, MonDReg=0xCAFEF00D, monitor_ready=1.
REQ-032 addr=0x1FF then two OCIMEM_B writes 0x11,0x22 -> mem_addr 0x1FF then 0x000, wdata matches.
REQ-033 take_action_break_b and tracectrl same cycle -> single brk_wr brk_sel=1, cmd_collision=1.
REQ-034 Stall mem_ack, issue 6 strobes -> 4 queued (FIFO_DEPTH), cmd_overflow=1, queued commands execute in order.
REQ-035 Read with no ack -> mem_req drops after 255 WAIT cycles, monitor_error=1; next OCIMEM_A clears it.
REQ-036 Reset asserted in WAIT -> all outputs at reset values next cycle, subsequent stray mem_ack no effect.

Source files
------------

// File: rtl/nios_debug_pkg.sv
// nios_debug_pkg
// Shared types for the debug action sequencer: command opcodes, sequencer
// FSM states, the 41-bit queued command word and break/trace register selects.
package nios_debug_pkg;

  typedef enum logic [2:0] {
    OP_OCIMEM_A  = 3'd0,
    OP_OCIMEM_B  = 3'd1,
    OP_BREAK_A   = 3'd2,
    OP_BREAK_B   = 3'd3,
    OP_BREAK_C   = 3'd4,
    OP_TRACECTRL = 3'd5
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_WAIT     = 2'd2,
    ST_COMPLETE = 2'd3
  } state_e;

  // Queued command: opcode in the top three bits, JTAG payload below.
  typedef struct packed {
    opcode_e     op;
    logic [37:0] jdo;
  } cmd_t;

  localparam int CMD_W = 41;

  localparam logic [1:0] BRK_SEL_A     = 2'd0;
  localparam logic [1:0] BRK_SEL_B     = 2'd1;
  localparam logic [1:0] BRK_SEL_C     = 2'd2;
  localparam logic [1:0] BRK_SEL_TRACE = 2'd3;

  // Break/trace register select for a break-class opcode (opcode - 2).
  function automatic logic [1:0] brk_sel_of(input opcode_e op);
    logic [1:0] sel;
    case (op)
      OP_BREAK_A:   sel = BRK_SEL_A;
      OP_BREAK_B:   sel = BRK_SEL_B;
      OP_BREAK_C:   sel = BRK_SEL_C;
      OP_TRACECTRL: sel = BRK_SEL_TRACE;
      default:      sel = BRK_SEL_A;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/debug_cmd_fifo.sv
// debug_cmd_fifo
// Synchronous FIFO for queued debug commands.
//   clk, reset     : clock, synchronous active-high reset
//   push_i/wdata_i : write request and data; ignored when full unless a pop
//                    happens in the same cycle
//   pop_i/rdata_o  : read request; rdata_o always shows the head entry
//   full_o/empty_o : occupancy flags
module debug_cmd_fifo
  import nios_debug_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok_s  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot being written while full.
  assign push_ok_s = push_i & (~full_o | pop_ok_s);
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  // Read/write pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array write; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/nios_debug_action_sequencer.sv
// nios_debug_action_sequencer
// Queues host debug commands and executes them one at a time against the OCI
// memory port or the break/trace register write port.
//   clk, reset                 : clock, synchronous active-high reset
//   take_action_* , jdo        : single-cycle command strobes and payload
//   mem_req/write/addr/wdata   : OCI memory request, held until mem_ack
//   mem_ack, mem_rdata         : OCI memory completion
//   brk_wr, brk_sel, brk_data  : one-cycle break/trace register write
//   MonDReg, monitor_ready/err : host-visible result of the last command
//   cmd_overflow/cmd_collision : sticky queue error flags
module nios_debug_action_sequencer
  import nios_debug_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_action_break_a,
  input  logic        take_action_break_b,
  input  logic        take_action_break_c,
  input  logic        take_action_tracectrl,
  input  logic [37:0] jdo,
  output logic        mem_req,
  output logic        mem_write,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        brk_wr,
  output logic [1:0]  brk_sel,
  output logic [31:0] brk_data,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  output logic        cmd_overflow,
  output logic        cmd_collision
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d, head_s, push_cmd_s;
  logic [8:0]       addr_q, addr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic        mem_req_q, mem_req_d, mem_write_q, mem_write_d;
  logic [8:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        brk_wr_q, brk_wr_d;
  logic [1:0]  brk_sel_q, brk_sel_d;
  logic [31:0] brk_data_q, brk_data_d, mondreg_q, mondreg_d;
  logic        ready_q, ready_d, error_q, error_d;
  logic        overflow_q, overflow_d, collision_q, collision_d;
  logic [5:0]  stb_s;
  logic        push_s, pop_s, full_s, empty_s, multi_s, ack_s;
  opcode_e     push_op_s;
  logic        unused_cmd_s;

  assign stb_s = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                  take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};
  // More than one strobe bit set means some commands are dropped.
  assign multi_s = |(stb_s & (stb_s - 6'd1));
  assign push_cmd_s.op  = push_op_s;
  assign push_cmd_s.jdo = jdo;
  // An ack only counts while a request is actually outstanding.
  assign ack_s = mem_ack & mem_req_q;
  assign unused_cmd_s = ^{cmd_q.jdo[37:9], head_s.jdo[37:35]};

  // Strobe priority encoder: lowest opcode wins.
  always_comb begin
    push_s    = 1'b1;
    push_op_s = OP_OCIMEM_A;
    if      (stb_s[0]) push_op_s = OP_OCIMEM_A;
    else if (stb_s[1]) push_op_s = OP_OCIMEM_B;
    else if (stb_s[2]) push_op_s = OP_BREAK_A;
    else if (stb_s[3]) push_op_s = OP_BREAK_B;
    else if (stb_s[4]) push_op_s = OP_BREAK_C;
    else if (stb_s[5]) push_op_s = OP_TRACECTRL;
    else               push_s    = 1'b0;
  end

  debug_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (push_cmd_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Sequencer next state; request outputs are decoded from the FIFO head at
  // pop time so they are already registered in the EXEC cycle.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    brk_wr_d    = 1'b0;
    brk_sel_d   = brk_sel_q;
    brk_data_d  = brk_data_q;
    mondreg_d   = mondreg_q;
    ready_d     = ready_q;
    error_d     = error_q;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          cmd_d   = head_s;
          ready_d = 1'b0;
          state_d = ST_EXEC;
          case (head_s.op)
            OP_OCIMEM_A: begin
              error_d = 1'b0;
              if (head_s.jdo[17]) begin
                mem_req_d   = 1'b1;
                mem_write_d = 1'b0;
                mem_addr_d  = head_s.jdo[8:0];
              end else begin
                mem_req_d   = 1'b0;
              end
            end
            OP_OCIMEM_B: begin
              mem_req_d   = 1'b1;
              mem_write_d = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = head_s.jdo[34:3];
            end
            OP_BREAK_A, OP_BREAK_B, OP_BREAK_C, OP_TRACECTRL: begin
              brk_wr_d   = 1'b1;
              brk_sel_d  = brk_sel_of(head_s.op);
              brk_data_d = head_s.jdo[31:0];
            end
            default: state_d = ST_COMPLETE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cmd_q.op == OP_OCIMEM_A) addr_d = cmd_q.jdo[8:0];
        else                         addr_d = addr_q;
        if (mem_req_q) begin
          if (ack_s) begin
            mem_req_d = 1'b0;
            state_d   = ST_COMPLETE;
            if (mem_write_q) addr_d    = addr_q + 9'd1;
            else             mondreg_d = mem_rdata;
          end else begin
            tmo_d   = '0;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_COMPLETE;
        end
      end
      ST_WAIT: begin
        if (ack_s) begin
          mem_req_d = 1'b0;
          state_d   = ST_COMPLETE;
          if (mem_write_q) addr_d    = addr_q + 9'd1;
          else             mondreg_d = mem_rdata;
        end else if (tmo_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_COMPLETE;
        end else begin
          tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_COMPLETE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: overflow only when a full FIFO is not also being popped.
  assign overflow_d  = overflow_q | (push_s & full_s & ~pop_s);
  assign collision_d = collision_q | multi_s;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= 9'd0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 9'd0;
      mem_wdata_q <= 32'd0;
      brk_wr_q    <= 1'b0;
      brk_sel_q   <= 2'd0;
      brk_data_q  <= 32'd0;
      mondreg_q   <= 32'd0;
      ready_q     <= 1'b1;
      error_q     <= 1'b0;
      overflow_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      brk_wr_q    <= brk_wr_d;
      brk_sel_q   <= brk_sel_d;
      brk_data_q  <= brk_data_d;
      mondreg_q   <= mondreg_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      overflow_q  <= overflow_d;
      collision_q <= collision_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign brk_wr        = brk_wr_q;
  assign brk_sel       = brk_sel_q;
  assign brk_data      = brk_data_q;
  assign MonDReg       = mondreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign cmd_overflow  = overflow_q;
  assign cmd_collision = collision_q;

endmodule

// File: tb/tb_nios_debug_action_sequencer.sv
// Directed self-checking bench for nios_debug_action_sequencer.
module tb_nios_debug_action_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  stb;
  logic [37:0] jdo;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_write, brk_wr, monitor_ready, monitor_error;
  logic        cmd_overflow, cmd_collision;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, brk_data, MonDReg;
  logic [1:0]  brk_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_debug_action_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .take_action_ocimem_a  (stb[0]),
    .take_action_ocimem_b  (stb[1]),
    .take_action_break_a   (stb[2]),
    .take_action_break_b   (stb[3]),
    .take_action_break_c   (stb[4]),
    .take_action_tracectrl (stb[5]),
    .jdo                   (jdo),
    .mem_req               (mem_req),
    .mem_write             (mem_write),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_ack               (mem_ack),
    .mem_rdata             (mem_rdata),
    .brk_wr                (brk_wr),
    .brk_sel               (brk_sel),
    .brk_data              (brk_data),
    .MonDReg               (MonDReg),
    .monitor_ready         (monitor_ready),
    .monitor_error         (monitor_error),
    .cmd_overflow          (cmd_overflow),
    .cmd_collision         (cmd_collision)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe of opcode op; returns in cycle N+1.
  task automatic send(input int op, input logic [37:0] d);
    stb = 6'd1 << op;
    jdo = d;
    step();
    stb = 6'd0;
    jdo = 38'd0;
  endtask

  function automatic logic [37:0] a_jdo(input logic go, input logic [8:0] a);
    return {20'd0, go, 8'd0, a};
  endfunction

  function automatic logic [37:0] b_jdo(input logic [31:0] w);
    return {3'd0, w, 3'd0};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({mem_req, mem_write, brk_wr, monitor_ready, monitor_error, cmd_overflow, cmd_collision} !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0001000", {mem_req, mem_write, brk_wr, monitor_ready, monitor_error, cmd_overflow, cmd_collision});
    end
    checks++;
    if ({mem_addr, mem_wdata, brk_sel, brk_data, MonDReg} !== 107'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, brk_sel, brk_data, MonDReg});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_read();
    send(0, a_jdo(1'b1, 9'h010));
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL read_req_n1: got %b expected 0", mem_req); end
    step();
    checks++;
    if ({mem_req, mem_write, mem_addr, monitor_ready} !== {1'b1, 1'b0, 9'h010, 1'b0}) begin
      errors++;
      $display("FAIL read_req_n2: got req=%b wr=%b addr=%h rdy=%b expected 1 0 010 0", mem_req, mem_write, mem_addr, monitor_ready);
    end
    step();
    step();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 9'h010}) begin
      errors++;
      $display("FAIL read_hold: got req=%b addr=%h expected 1 010", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    checks++;
    if ({mem_req, MonDReg} !== {1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL read_data: got req=%b MonDReg=%h expected 0 cafef00d", mem_req, MonDReg);
    end
    step();
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL read_ready: got %b expected 1", monitor_ready); end
  endtask

  task automatic test_write_wrap();
    send(0, a_jdo(1'b0, 9'h1FF));
    step();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL setaddr_noreq: got %b expected 0", mem_req); end
    step();
    step();
    send(1, b_jdo(32'h11));
    step();
    checks++;
    if ({mem_req, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h1FF, 32'h11}) begin
      errors++;
      $display("FAIL write1: got req=%b wr=%b addr=%h wdata=%h expected 1 1 1ff 00000011", mem_req, mem_write, mem_addr, mem_wdata);
    end
    // Ack in the very first request cycle.
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL write1_done: got %b expected 0", mem_req); end
    step();
    send(1, b_jdo(32'h22));
    step();
    checks++;
    if ({mem_req, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h000, 32'h22}) begin
      errors++;
      $display("FAIL write2_wrap: got req=%b wr=%b addr=%h wdata=%h expected 1 1 000 00000022", mem_req, mem_write, mem_addr, mem_wdata);
    end
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    step();
  endtask

  task automatic test_break_ops();
    for (int op = 2; op <= 5; op++) begin
      send(op, {6'd0, 32'hB000_0000 + 32'(op)});
      checks++;
      if (brk_wr !== 1'b0) begin errors++; $display("FAIL brk_early op%0d: got %b expected 0", op, brk_wr); end
      step();
      checks++;
      if ({brk_wr, brk_sel, brk_data} !== {1'b1, 2'(op - 2), 32'hB000_0000 + 32'(op)}) begin
        errors++;
        $display("FAIL brk_write op%0d: got wr=%b sel=%0d data=%h", op, brk_wr, brk_sel, brk_data);
      end
      step();
      checks++;
      if (brk_wr !== 1'b0) begin errors++; $display("FAIL brk_pulse op%0d: got %b expected 0", op, brk_wr); end
      step();
    end
    checks++;
    if (cmd_collision !== 1'b0) begin errors++; $display("FAIL no_collision: got %b expected 0", cmd_collision); end
  endtask

  task automatic test_collision();
    int pulses;
    logic [1:0] sel_seen;
    pulses = 0;
    sel_seen = 2'd0;
    stb = 6'b101000;
    jdo = {6'd0, 32'h12345678};
    step();
    stb = 6'd0;
    for (int i = 0; i < 8; i++) begin
      if (brk_wr === 1'b1) begin
        pulses++;
        sel_seen = brk_sel;
      end
      step();
    end
    checks++;
    if ({pulses[3:0], sel_seen, brk_data} !== {4'd1, 2'd1, 32'h12345678}) begin
      errors++;
      $display("FAIL collision_brk: got pulses=%0d sel=%0d data=%h expected 1 1 12345678", pulses, sel_seen, brk_data);
    end
    checks++;
    if (cmd_collision !== 1'b1) begin errors++; $display("FAIL collision_flag: got %b expected 1", cmd_collision); end
  endtask

  task automatic test_overflow();
    logic [31:0] got [8];
    int n;
    n = 0;
    send(0, a_jdo(1'b1, 9'h020));
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      send(2, {6'd0, 32'h100 + 32'(i)});
      if (i == 3) begin
        checks++;
        if (cmd_overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_4: got %b expected 0", cmd_overflow); end
      end
      if (i == 4) begin
        checks++;
        if (cmd_overflow !== 1'b1) begin errors++; $display("FAIL ovf_at_5: got %b expected 1", cmd_overflow); end
      end
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h5A5A5A5A;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    for (int c = 0; c < 30; c++) begin
      if (brk_wr === 1'b1) begin
        if (n < 8) got[n] = brk_data;
        n++;
      end
      step();
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      checks++;
      if (got[k] !== 32'h100 + 32'(k)) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", k, got[k], 32'h100 + 32'(k)); end
    end
    checks++;
    if ({MonDReg, cmd_overflow} !== {32'h5A5A5A5A, 1'b1}) begin
      errors++;
      $display("FAIL ovf_read: got MonDReg=%h ovf=%b expected 5a5a5a5a 1", MonDReg, cmd_overflow);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    send(0, a_jdo(1'b1, 9'h055));
    step();
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 400) begin
      cnt++;
      step();
    end
    // One EXEC cycle plus TIMEOUT WAIT cycles.
    checks++;
    if (cnt != 256) begin errors++; $display("FAIL timeout_len: got %0d expected 256", cnt); end
    checks++;
    if ({monitor_error, MonDReg} !== {1'b1, 32'h5A5A5A5A}) begin
      errors++;
      $display("FAIL timeout_err: got err=%b MonDReg=%h expected 1 5a5a5a5a", monitor_error, MonDReg);
    end
    step();
    step();
    send(0, a_jdo(1'b0, 9'h000));
    step();
    checks++;
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", monitor_error); end
    step();
    step();
  endtask

  task automatic test_reset_in_wait();
    send(0, a_jdo(1'b1, 9'h0AA));
    step();
    step();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_wait_req: got %b expected 1", mem_req); end
    reset = 1'b1;
    step();
    checks++;
    if ({mem_req, mem_write, brk_wr, monitor_ready, monitor_error, cmd_overflow, cmd_collision} !== 7'b0001000) begin
      errors++;
      $display("FAIL rst_wait_flags: got %b expected 0001000", {mem_req, mem_write, brk_wr, monitor_ready, monitor_error, cmd_overflow, cmd_collision});
    end
    checks++;
    if ({mem_addr, mem_wdata, brk_sel, brk_data, MonDReg} !== 107'd0) begin
      errors++;
      $display("FAIL rst_wait_data: got %h expected 0", {mem_addr, mem_wdata, brk_sel, brk_data, MonDReg});
    end
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step();
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    step();
    checks++;
    if ({mem_req, MonDReg, monitor_ready} !== {1'b0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL stray_ack: got req=%b MonDReg=%h rdy=%b expected 0 0 1", mem_req, MonDReg, monitor_ready);
    end
  endtask

  initial begin
    reset = 1'b1;
    stb = 6'd0;
    jdo = 38'd0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    test_reset();
    test_read();
    test_write_wrap();
    test_break_ops();
    test_collision();
    test_overflow();
    test_timeout();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
